// File: rtl/ooo_fetch_queue_if.sv
// Fetch-queue bus: I-cache request/response, predict-stage head port and redirect inputs.
// The fetch queue takes the master side; the cache/predictor/commit environment takes the slave side.
interface ooo_fetch_queue_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fetch_en;
    logic        pred_redirect;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] flush_addr;

    modport master (
        output imem_addr, imem_rmask, out_valid, out_pc, out_inst, fetch_en,
        input  imem_resp, imem_rdata, deq, pred_redirect, pred_target, flush, flush_addr
    );

    modport slave (
        input  imem_addr, imem_rmask, out_valid, out_pc, out_inst, fetch_en,
        output imem_resp, imem_rdata, deq, pred_redirect, pred_target, flush, flush_addr
    );
endinterface

// File: rtl/ooo_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one I-cache read in flight and
// buffers returned instructions in a DEPTH-entry FIFO feeding the predict stage.
module ooo_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input logic             clk,
    input logic             rst,
    ooo_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          fetch_en_r;

    logic          redir;
    logic [31:0]   target;
    logic          issue;
    logic          push;
    logic          pop;

    // Only one read is ever outstanding, so count < DEPTH at issue guarantees a slot for its response.
    always_comb begin
        redir  = bus.flush | bus.pred_redirect;
        target = bus.flush ? bus.flush_addr : bus.pred_target;
        issue  = !rst && (state == IDLE) && !redir && (count < FULL);
        push   = (state == WAIT) && bus.imem_resp && !redir;
        pop    = bus.deq && (count != '0) && !redir;
    end

    always_comb begin
        bus.imem_rmask = issue ? 4'hF : 4'h0;
        bus.imem_addr  = pc;
        bus.out_valid  = (count != '0);
        bus.out_pc     = (count != '0) ? pc_q[head]   : '1;
        bus.out_inst   = (count != '0) ? inst_q[head] : '1;
        bus.fetch_en   = fetch_en_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_en_r <= 1'b0;
        end else begin
            if (redir) begin
                pc         <= target;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                fetch_en_r <= 1'b0;
            end else begin
                if (issue) begin
                    pc     <= pc + 32'd4;
                    req_pc <= pc;
                end
                if (push) begin
                    pc_q[tail]   <= req_pc;
                    inst_q[tail] <= bus.imem_rdata;
                    tail         <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                // New head: a pop that leaves something behind, or the first push into an empty queue.
                fetch_en_r <= (pop && (push || count > (PW + 1)'(1))) || (push && count == '0);
            end

            case (state)
                IDLE:    if (issue) state <= WAIT;
                WAIT: begin
                    if (redir)              state <= bus.imem_resp ? IDLE : DISCARD;
                    else if (bus.imem_resp) state <= IDLE;
                end
                DISCARD: if (bus.imem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ooo_fetch_queue.sv
// Randomized scoreboard bench for ooo_fetch_queue: a behavioural model of the fetch PC
// stream and instruction queue is checked against the DUT outputs every cycle.
module tb_ooo_fetch_queue;
    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ooo_fetch_queue_if bus ();

    ooo_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    // Scoreboard: {pc, inst} entries the queue is expected to hold, oldest first.
    logic [63:0] sb [$];
    logic [31:0] exp_pc;
    logic [31:0] req_pc;
    logic        busy;
    logic        live;
    logic        exp_fe;

    logic        m_redir;
    logic [31:0] m_tgt;
    logic        m_issue;
    logic        m_pushed;
    logic        m_popped;
    int unsigned m_n0;
    logic [63:0] m_head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor / reference model: checks outputs for this cycle, then applies the cycle's inputs.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_pc = RESET_PC;
            req_pc = '0;
            busy   = 1'b0;
            live   = 1'b0;
            exp_fe = 1'b0;
        end else begin
            m_redir = bus.flush | bus.pred_redirect;
            m_tgt   = bus.flush ? bus.flush_addr : bus.pred_target;
            m_issue = !busy && !m_redir && (sb.size() < DEPTH);
            m_head  = (sb.size() != 0) ? sb[0] : '1;

            check("imem_rmask", {28'd0, bus.imem_rmask}, m_issue ? 32'hF : 32'h0);
            if (m_issue) check("imem_addr", bus.imem_addr, exp_pc);
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
            check("out_pc", bus.out_pc, m_head[63:32]);
            check("out_inst", bus.out_inst, m_head[31:0]);
            check("fetch_en", {31'd0, bus.fetch_en}, {31'd0, exp_fe});

            m_pushed = 1'b0;
            m_popped = 1'b0;
            m_n0     = sb.size();
            if (m_redir) begin
                sb.delete();
                exp_pc = m_tgt;
                live   = 1'b0;
                exp_fe = 1'b0;
                if (bus.imem_resp) busy = 1'b0;
            end else begin
                if (bus.deq && m_n0 != 0) begin
                    void'(sb.pop_front());
                    m_popped = 1'b1;
                end
                if (bus.imem_resp && busy && live) begin
                    sb.push_back({req_pc, bus.imem_rdata});
                    m_pushed = 1'b1;
                end
                if (bus.imem_resp) busy = 1'b0;
                exp_fe = (m_popped && sb.size() != 0) || (m_pushed && m_n0 == 0);
                if (m_issue) begin
                    busy   = 1'b1;
                    live   = 1'b1;
                    req_pc = exp_pc;
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // Cache responder state (driver side).
    logic        pend = 1'b0;
    int unsigned wait_cnt = 0;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return 32'hFFFF_FFF8;
            1:       return RESET_PC + 32'h100;
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.imem_resp     = 1'b0;
        bus.imem_rdata    = '0;
        bus.deq           = 1'b0;
        bus.pred_redirect = 1'b0;
        bus.pred_target   = '0;
        bus.flush         = 1'b0;
        bus.flush_addr    = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst  = 1'b1;
        pend = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle of stimulus; force_both drives flush and pred_redirect together.
    task automatic cycle(input int unsigned max_lat, input int unsigned deq_pct,
                         input int unsigned redir_pct, input logic force_both);
        @(posedge clk); #1;
        bus.imem_resp = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = pend_data;
                pend           = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
        bus.deq           = ($urandom_range(99) < deq_pct);
        bus.flush         = force_both || ($urandom_range(99) < redir_pct);
        bus.pred_redirect = force_both || ($urandom_range(99) < redir_pct);
        bus.flush_addr    = force_both ? 32'h1eceb200 : pick_target();
        bus.pred_target   = force_both ? 32'h1eceb300 : pick_target();
        @(negedge clk);
        if (bus.imem_rmask == 4'hF) begin
            pend      = 1'b1;
            wait_cnt  = $urandom_range(max_lat);
            pend_data = $urandom;
        end
    endtask

    task automatic run(input int unsigned n, input int unsigned max_lat,
                       input int unsigned deq_pct, input int unsigned redir_pct);
        for (int unsigned c = 0; c < n; c++) cycle(max_lat, deq_pct, redir_pct, 1'b0);
    endtask

    initial begin
        clear_inputs();
        do_reset();
        // Fill to capacity with no consumer; rmask must then stay low.
        run(30, 0, 0, 0);
        run(1, 0, 100, 0);
        run(8, 0, 0, 0);
        // Full-queue streaming with continuous dequeue.
        run(20, 0, 100, 0);
        // Slow cache with redirects landing while a read is outstanding.
        run(150, 3, 40, 10);
        // Simultaneous flush and predictor redirect: flush target wins.
        run(3, 1, 0, 0);
        cycle(1, 0, 0, 1'b1);
        run(6, 1, 0, 0);
        // Long mixed random phase, then reset in mid-traffic.
        run(3000, 3, 60, 4);
        do_reset();
        run(300, 2, 50, 6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
